key_generator_aes: RTL and testbench
====================================

// Module: key_generator_aes
// PURPOSE
// - Sequential AES key-expansion engine (FIPS-197 sec. 5.2) for AES-128/192/256.
// - Takes a cipher key on a start pulse and computes one expanded word per clock.
// - Publishes all Nr+1 round keys as one flat bus to the cipher datapath
//   (addRoundKey and the round logic).
// PARAMETERS
// - Nk  4   key length in 32-bit words; legal pairs (Nk,Nr) = (4,10), (6,12), (8,14).
// - Nr  10  number of rounds; any other pair is an elaboration-time error.
// PORTS
// - clk         in   1               clock, rising edge
// - reset       in   1               synchronous, active-high
// - start       in   1               request expansion of key; sampled only while idle
// - key         in   32*Nk           cipher key; word w[0] = key[32*Nk-1 -: 32]
// - busy        out  1               expansion in progress
// - done        out  1               one-cycle pulse: round_keys complete
// - round_keys  out  128*(Nr+1)      round r = round_keys[128*(Nr+1)-1-128*r -: 128]
// BEHAVIOUR
// - Interface decision (fixed): one clock; reset is synchronous and active-high
//   (ports clk, reset).
// - Reset: busy=0, done=0, round_keys=0, word counter=0.
// - Reset asserted mid-expansion aborts it; there is no partial result.
// - Idle with start=1 at edge E0:
//   - key is latched and w[0..Nk-1] are written.
//   - busy=1 and i=Nk.
//   - key changes after E0 are ignored.
// - Busy: each edge writes w[i] = w[i-Nk] ^ temp, then increments i. temp is formed from w[i-1]:
//   - i%Nk==0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0}.
//   - Nk==8 and i%Nk==4: temp = SubWord(w[i-1]).
//   - Otherwise: temp = w[i-1].
// - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. RotWord = {b1,b2,b3,b0}.
// - SubWord applies the AES S-box to each of the 4 bytes.
// - Last word is i = 4*(Nr+1)-1. The edge writing it clears busy and sets done for exactly one cycle.
//   - Latency E0 -> done = 4*(Nr+1)-Nk edges: 40 / 46 / 52.
// - round_keys:
//   - Written word-by-word; unwritten words keep their previous value.
//   - Valid from the done cycle and held until the next accepted start or reset.
// - start while busy: ignored, with no restart and no effect on the result.
// - start in the same cycle as done: accepted only on the next idle cycle.
//   done does not block it because busy=0 after that edge.
// - No combinational path from start or key to the outputs; all outputs are registered.
// STRUCTURE
// - Package aes_pkg holds:
//   - 256-entry S-box constant table and sbox(byte) function.
//   - Rcon table.
//   - Legal (Nk,Nr) constants.
//   - Shared with subBytes, Shiftrows and addRoundKey.
// - Sub-module aes_sbox: combinational 8-bit lookup. 4 instances implement SubWord.
// - Shiftrows and addRoundKey remain separate combinational blocks and are not part of this module.
// TESTING
// - AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, start
//   -> done after 40 edges;
//   -> round1 = a0fafe1788542cb123a339392a6c7605;
//   -> round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
// - AES-128: key 000102030405060708090a0b0c0d0e0f
//   -> round10 = 13111d7fe3944a17f307a78b4d2b30c5;
//   -> round0 = key.
// - AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//   -> w[6] = fe0c91f7, w[51] = 01002202, done after 46 edges.
// - AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4
//   -> w[8] = 9ba35411, w[59] = 706c631e, done after 52 edges.
// - start pulsed again and key changed while busy
//   -> result still matches the original key and done fires once.
// - reset asserted at edge 20 of an AES-128 run
//   -> busy=0, done=0, round_keys=0 on the next cycle;
//   -> a new start completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box table, round constants, supported (Nk,Nr) pairs.
// No latency (constants and pure functions only).
// No flow control.
package aes_pkg;

  localparam int NK_128 = 4;
  localparam int NR_128 = 10;
  localparam int NK_192 = 6;
  localparam int NR_192 = 12;
  localparam int NK_256 = 8;
  localparam int NR_256 = 14;

  // Forward S-box. Entry 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon[1..10], Rcon[1] in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  // Valid for idx 1..10; anything else returns 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    if (idx == 4'd0 || idx > 4'd10) return 8'h00;
    return RCON_TABLE[79 - 8*(int'(idx) - 1) -: 8];
  endfunction

  function automatic bit legal_cfg(input int nk, input int nr);
    return (nk == NK_128 && nr == NR_128) ||
           (nk == NK_192 && nr == NR_192) ||
           (nk == NK_256 && nr == NR_256);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box lookup.
// Combinational, zero cycles.
// No flow control.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = sbox(byte_i);

endmodule

// File: rtl/key_generator_aes.sv
// AES-128/192/256 key expansion, one expanded word per clock, all round keys on one bus.
// Latency start-accept edge -> done = 4*(Nr+1)-Nk edges (40/46/52).
// No backpressure: start is only sampled while idle; extra starts while busy are dropped.
module key_generator_aes
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [32*Nk-1:0]      key,
  output logic                  busy,
  output logic                  done,
  output logic [128*(Nr+1)-1:0] round_keys
);

  localparam int KW  = 32*Nk;
  localparam int NW  = 4*(Nr+1);
  localparam int RKW = 128*(Nr+1);

  if (!legal_cfg(Nk, Nr)) begin : g_bad_cfg
    $error("key_generator_aes: unsupported (Nk,Nr) pair");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t         state_q;
  logic [31:0]    win_q [Nk];   // win_q[0] = w[i-Nk], win_q[Nk-1] = w[i-1]
  logic [5:0]     i_q;          // index of the word written on the next busy edge
  logic [2:0]     pos_q;        // i % Nk
  logic [3:0]     rc_q;         // i / Nk, used only when pos_q == 0
  logic           busy_q;
  logic           done_q;
  logic [RKW-1:0] rk_q;

  logic [31:0] prev_w;
  logic [31:0] rot_w;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_w;
  logic [31:0] word_d;

  // SubWord: four byte-wide S-box lookups
  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .byte_i (sub_in[8*g +: 8]),
      .byte_o (sub_out[8*g +: 8])
    );
  end

  // Next expanded word from the sliding window of the last Nk words
  always_comb begin
    prev_w = win_q[Nk-1];
    rot_w  = {prev_w[23:0], prev_w[31:24]};
    sub_in = (pos_q == 3'd0) ? rot_w : prev_w;
    if (pos_q == 3'd0) begin
      temp_w = sub_out ^ {rcon(rc_q), 24'h0};
    end else if (Nk == 8 && pos_q == 3'd4) begin
      temp_w = sub_out;
    end else begin
      temp_w = prev_w;
    end
    word_d = win_q[0] ^ temp_w;
  end

  // Control FSM, window shift and round-key bus writes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int j = 0; j < Nk; j++) win_q[j] <= '0;
      i_q     <= '0;
      pos_q   <= '0;
      rc_q    <= 4'd1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rk_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int j = 0; j < Nk; j++) begin
              win_q[j]                  <= key[KW-1-32*j -: 32];
              rk_q[RKW-1-32*j -: 32]    <= key[KW-1-32*j -: 32];
            end
            i_q     <= 6'(Nk);
            pos_q   <= 3'd0;
            rc_q    <= 4'd1;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          rk_q[RKW-1-32*int'(i_q) -: 32] <= word_d;
          for (int j = 0; j < Nk-1; j++) win_q[j] <= win_q[j+1];
          win_q[Nk-1] <= word_d;
          i_q   <= i_q + 6'd1;
          pos_q <= (pos_q == 3'(Nk-1)) ? 3'd0 : pos_q + 3'd1;
          if (pos_q == 3'd0) rc_q <= rc_q + 4'd1;
          // The edge that writes the final word ends the run
          if (i_q == 6'(NW-1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign round_keys = rk_q;

endmodule

// File: tb/tb_key_generator_aes.sv
module tb_key_generator_aes;

  logic clk = 1'b0;
  logic reset;

  logic         start128, start192, start256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic         busy128, busy192, busy256;
  logic         done128, done192, done256;
  logic [1407:0] rk128;
  logic [1663:0] rk192;
  logic [1919:0] rk256;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY_C = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_D = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_generator_aes #(.Nk(4), .Nr(10)) u_dut128 (
    .clk(clk), .reset(reset), .start(start128), .key(key128),
    .busy(busy128), .done(done128), .round_keys(rk128));

  key_generator_aes #(.Nk(6), .Nr(12)) u_dut192 (
    .clk(clk), .reset(reset), .start(start192), .key(key192),
    .busy(busy192), .done(done192), .round_keys(rk192));

  key_generator_aes #(.Nk(8), .Nr(14)) u_dut256 (
    .clk(clk), .reset(reset), .start(start256), .key(key256),
    .busy(busy256), .done(done256), .round_keys(rk256));

  function automatic logic [127:0] round128(input int r);
    return rk128[1407 - 128*r -: 128];
  endfunction
  function automatic logic [31:0] word192(input int j);
    return rk192[1663 - 32*j -: 32];
  endfunction
  function automatic logic [31:0] word256(input int j);
    return rk256[1919 - 32*j -: 32];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (the accepting edge E0), then scramble the key
  task automatic start_key(input int sel);
    case (sel)
      0: start128 = 1'b1;
      1: start192 = 1'b1;
      default: start256 = 1'b1;
    endcase
    @(posedge clk); #1;
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    key128 = ~key128; key192 = ~key192; key256 = ~key256;
  endtask

  // Count edges after E0 until done is seen, bounded
  task automatic wait_done(input int sel, input int exp_edges, input string tag);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1; n++;
      case (sel)
        0: seen = done128;
        1: seen = done192;
        default: seen = done256;
      endcase
    end
    chk(tag, 128'(n), 128'(exp_edges));
  endtask

  initial begin
    int dn;
    int first;
    reset = 1'b1;
    start128 = 1'b0; start192 = 1'b0; start256 = 1'b0;
    key128 = '0; key192 = '0; key256 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy128), 128'd0);
    chk("rst_done", 128'(done128), 128'd0);
    chk("rst_rk128", 128'(|rk128), 128'd0);
    chk("rst_rk256", 128'(|rk256), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // AES-128, key A
    key128 = KEY_A;
    start_key(0);
    chk("a_busy_e0", 128'(busy128), 128'd1);
    wait_done(0, 40, "a_latency");
    chk("a_busy_at_done", 128'(busy128), 128'd0);
    chk("a_round0", round128(0), KEY_A);
    chk("a_round1", round128(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a_round2", round128(2), 128'hf2c295f27a96b9435935807a7359f67f);
    chk("a_round10", round128(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk); #1;
    chk("a_done_pulse", 128'(done128), 128'd0);
    chk("a_hold_round10", round128(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-128, key B
    key128 = KEY_B;
    start_key(0);
    wait_done(0, 40, "b_latency");
    chk("b_round0", round128(0), KEY_B);
    chk("b_round1", round128(1), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("b_round10", round128(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Restart attempt with a different key while busy
    key128 = KEY_A;
    start_key(0);
    dn = 0; first = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done128) begin
        dn++;
        if (first == 0) first = c;
      end
      if (c == 5) begin start128 = 1'b1; key128 = KEY_B; end
      if (c == 6) start128 = 1'b0;
    end
    chk("rs_done_count", 128'(dn), 128'd1);
    chk("rs_done_edge", 128'(first), 128'd40);
    chk("rs_round10", round128(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset sampled at edge 20 of an AES-128 run
    key128 = KEY_B;
    start_key(0);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_busy", 128'(busy128), 128'd0);
    chk("mr_done", 128'(done128), 128'd0);
    chk("mr_rk_zero", 128'(|rk128), 128'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    key128 = KEY_B;
    start_key(0);
    wait_done(0, 40, "mr_latency");
    chk("mr_round10", round128(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // AES-192
    key192 = KEY_C;
    start_key(1);
    wait_done(1, 46, "c_latency");
    chk("c_busy_at_done", 128'(busy192), 128'd0);
    chk("c_w6", 128'(word192(6)), 128'hfe0c91f7);
    chk("c_w51", 128'(word192(51)), 128'h01002202);

    // AES-256, then a start issued in the done cycle
    key256 = KEY_D;
    start_key(2);
    wait_done(2, 52, "d_latency");
    chk("d_w8", 128'(word256(8)), 128'h9ba35411);
    chk("d_w59", 128'(word256(59)), 128'h706c631e);
    key256 = KEY_D;
    start_key(2);
    chk("d2_busy", 128'(busy256), 128'd1);
    chk("d2_done_clear", 128'(done256), 128'd0);
    wait_done(2, 52, "d2_latency");
    chk("d2_w59", 128'(word256(59)), 128'h706c631e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
